// File: rtl/user_mem_pkg.sv
// Shared definitions for the user-project memory arbiter: FSM states,
// default memory window, and latency counter width.
package user_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        COOL
    } arb_state_t;

    localparam int          DEF_ADDR_W   = 10;
    localparam logic [31:0] DEF_BASE_ADR = 32'h3800_0000;
    localparam int          LAT_CNT_W    = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. The pick is combinational; the
// last-winner register only moves when the owner FSM commits a grant.
module rr_arb2 (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic req_cpu,
    input  logic req_dma,
    input  logic update,
    output logic pick_dma,
    output logic last_dma
);

    // On a tie the loser of the previous round wins; a lone requester always wins.
    always_comb begin
        if (req_cpu && req_dma) begin
            pick_dma = ~last_dma;
        end else begin
            pick_dma = req_dma;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            last_dma <= 1'b0;
        end else if (update) begin
            last_dma <= pick_dma;
        end
    end

endmodule

// File: rtl/user_mem_arbiter.sv
// Shares the single-port user memory between the CPU Wishbone slave path and
// the DMA master, serialising accesses and generating both acknowledges.
module user_mem_arbiter
    import user_mem_pkg::*;
#(
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter logic [31:0] BASE_ADR    = DEF_BASE_ADR,
    parameter int          MEM_LATENCY = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              dma_cyc_i,
    input  logic              dma_stb_i,
    input  logic              dma_we_i,
    input  logic [3:0]        dma_sel_i,
    input  logic [31:0]       dma_adr_i,
    input  logic [31:0]       dma_dat_i,
    output logic              dma_ack_o,
    output logic [31:0]       dma_dat_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              grant_dma_o
);

    arb_state_t           state, state_nxt;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 cpu_req, dma_req;
    logic                 pick_dma, owner_dma;
    logic                 grant, capture;
    logic                 owner_cyc, owner_we, aborted;
    logic                 unused_adr_bits;

    assign cpu_req   = wbs_cyc_i & wbs_stb_i &
                       (wbs_adr_i[31:ADDR_W+2] == BASE_ADR[31:ADDR_W+2]);
    assign dma_req   = dma_cyc_i & dma_stb_i;
    assign owner_cyc = owner_dma ? dma_cyc_i : wbs_cyc_i;
    assign grant_dma_o = owner_dma;

    assign unused_adr_bits = ^{wbs_adr_i[1:0], dma_adr_i[31:ADDR_W+2], dma_adr_i[1:0]};

    rr_arb2 u_rr_arb2 (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req_cpu  (cpu_req),
        .req_dma  (dma_req),
        .update   (grant),
        .pick_dma (pick_dma),
        .last_dma (owner_dma)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The mem_en_o cycle is not counted, so data is captured MEM_LATENCY cycles after it.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!mem_en_o && lat_cnt == LAT_CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = COOL;
            COOL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mem_en_o    <= 1'b0;
            mem_we_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            wbs_ack_o   <= 1'b0;
            dma_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
            dma_dat_o   <= '0;
            lat_cnt     <= '0;
            owner_we    <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            dma_ack_o <= 1'b0;
            if (grant) begin
                mem_en_o <= 1'b1;
                lat_cnt  <= LAT_CNT_W'(MEM_LATENCY);
                aborted  <= 1'b0;
                if (pick_dma) begin
                    mem_addr_o  <= dma_adr_i[ADDR_W+1:2];
                    mem_wdata_o <= dma_dat_i;
                    mem_we_o    <= dma_we_i ? dma_sel_i : 4'b0000;
                    owner_we    <= dma_we_i;
                end else begin
                    mem_addr_o  <= wbs_adr_i[ADDR_W+1:2];
                    mem_wdata_o <= wbs_dat_i;
                    mem_we_o    <= wbs_we_i ? wbs_sel_i : 4'b0000;
                    owner_we    <= wbs_we_i;
                end
            end else if (state == ACCESS) begin
                mem_en_o <= 1'b0;
                mem_we_o <= 4'b0000;
                // A dropped cycle cannot cancel the access, only its acknowledge.
                if (!owner_cyc) begin
                    aborted <= 1'b1;
                end
                if (capture) begin
                    lat_cnt <= '0;
                    if (owner_dma) begin
                        dma_ack_o <= owner_cyc && !aborted;
                        if (!owner_we) begin
                            dma_dat_o <= mem_rdata_i;
                        end
                    end else begin
                        wbs_ack_o <= owner_cyc && !aborted;
                        if (!owner_we) begin
                            wbs_dat_o <= mem_rdata_i;
                        end
                    end
                end else if (!mem_en_o) begin
                    lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_user_mem_arbiter.sv
// Scoreboard bench for user_mem_arbiter: directed timing cases, then random
// traffic from both masters checked against a word-level memory model.
module tb_user_mem_arbiter;

    localparam int          ADDR_W = 10;
    localparam int          WORDS  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h3800_0000;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i, wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;
    logic              dma_cyc_i, dma_stb_i, dma_we_i;
    logic [3:0]        dma_sel_i;
    logic [31:0]       dma_adr_i, dma_dat_i;
    logic              dma_ack_o;
    logic [31:0]       dma_dat_o;
    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
    logic              grant_dma_o;

    user_mem_arbiter #(
        .ADDR_W      (ADDR_W),
        .BASE_ADR    (BASE),
        .MEM_LATENCY (1)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .dma_cyc_i   (dma_cyc_i),
        .dma_stb_i   (dma_stb_i),
        .dma_we_i    (dma_we_i),
        .dma_sel_i   (dma_sel_i),
        .dma_adr_i   (dma_adr_i),
        .dma_dat_i   (dma_dat_i),
        .dma_ack_o   (dma_ack_o),
        .dma_dat_o   (dma_dat_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .grant_dma_o (grant_dma_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    logic [31:0] mem_model [WORDS];
    logic [31:0] ref_mem   [WORDS];
    logic [31:0] exp_cpu[$];
    logic [31:0] exp_dma[$];
    bit          ack_who[$];
    int          ack_cyc[$];
    logic [31:0] cpu_last, dma_last;
    int          checks = 0;
    int          errors = 0;
    int          cyc_cnt = 0;

    // Memory macro with one cycle of read latency, read-before-write.
    always @(posedge wb_clk_i) begin
        cyc_cnt <= cyc_cnt + 1;
        if (mem_en_o) begin
            mem_rdata_i <= mem_model[mem_addr_o];
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) mem_model[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0F03);
    endfunction

    function automatic logic [31:0] cpu_rand_adr();
        return BASE + 32'($urandom_range(0, 511)) * 32'd4 + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] dma_rand_adr();
        logic [31:0] a;
        a = $urandom();
        a[11:2] = 10'(512 + $urandom_range(0, 511));
        return a;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: condition observed, required never", name);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ctrl"}, 32'({wbs_ack_o, dma_ack_o, mem_en_o, grant_dma_o, mem_we_o}), 32'd0);
        check_output({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
        check_output({tag, "_wdata"}, mem_wdata_o, 32'd0);
        check_output({tag, "_wbs_dat"}, wbs_dat_o, 32'd0);
        check_output({tag, "_dma_dat"}, dma_dat_o, 32'd0);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    // Reference model: per-master last read data plus a byte-masked word array.
    task automatic push_expect(input bit is_dma, input bit we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel, input bit queue_it);
        int          word;
        logic [31:0] exp;
        word = int'(adr[ADDR_W+1:2]);
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[word][b*8 +: 8] = dat[b*8 +: 8];
            exp = is_dma ? dma_last : cpu_last;
        end else begin
            exp = ref_mem[word];
            if (is_dma) dma_last = exp;
            else        cpu_last = exp;
        end
        if (queue_it) begin
            if (is_dma) exp_dma.push_back(exp);
            else        exp_cpu.push_back(exp);
        end
    endtask

    task automatic drive(input bit is_dma, input bit we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        if (is_dma) begin
            dma_cyc_i = 1'b1; dma_stb_i = 1'b1; dma_we_i = we;
            dma_adr_i = adr;  dma_dat_i = dat;  dma_sel_i = sel;
        end else begin
            wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
            wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        end
    endtask

    task automatic release_bus(input bit is_dma);
        if (is_dma) begin
            dma_cyc_i = 1'b0; dma_stb_i = 1'b0; dma_we_i = 1'b0;
        end else begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input bit is_dma, input bit we, input logic [31:0] adr,
                                  input logic [31:0] dat, input logic [3:0] sel);
        bit got = 1'b0;
        push_expect(is_dma, we, adr, dat, sel, 1'b1);
        drive(is_dma, we, adr, dat, sel);
        for (int i = 0; i < 100 && !got; i++) begin
            step(1);
            got = is_dma ? dma_ack_o : wbs_ack_o;
        end
        if (!got) report_fail(is_dma ? "dma_ack_timeout" : "cpu_ack_timeout");
        release_bus(is_dma);
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        step(2);
        wb_rst_i = 1'b0;
        step(1);
        cpu_last = '0;
        dma_last = '0;
        exp_cpu.delete();
        exp_dma.delete();
    endtask

    // Monitor: pops the scoreboard on every acknowledge and polices ack spacing.
    initial begin : monitor
        bit prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (wb_rst_i) begin
                prev_ack = 1'b0;
            end else begin
                if (wbs_ack_o && dma_ack_o) report_fail("dual_ack");
                if ((wbs_ack_o || dma_ack_o) && prev_ack) report_fail("back_to_back_ack");
                if (wbs_ack_o) begin
                    ack_who.push_back(1'b0);
                    ack_cyc.push_back(cyc_cnt);
                    if (exp_cpu.size() == 0) report_fail("cpu_spurious_ack");
                    else check_output("cpu_dat", wbs_dat_o, exp_cpu.pop_front());
                end
                if (dma_ack_o) begin
                    ack_who.push_back(1'b1);
                    ack_cyc.push_back(cyc_cnt);
                    if (exp_dma.size() == 0) report_fail("dma_spurious_ack");
                    else check_output("dma_dat", dma_dat_o, exp_dma.pop_front());
                end
                prev_ack = wbs_ack_o | dma_ack_o;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL global_timeout: simulation still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed timing cases followed by concurrent random traffic.
    initial begin : stimulus
        logic [31:0] dma_a, cpu_a, dwd;
        int          en_seen, lat;
        bit          got;

        wb_rst_i = 1'b1;
        release_bus(1'b0);
        release_bus(1'b1);
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        dma_sel_i = '0; dma_adr_i = '0; dma_dat_i = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem_model[i] = init_word(i);
            ref_mem[i]   = init_word(i);
        end
        mem_model[4] = 32'hDEAD_BEEF;
        ref_mem[4]   = 32'hDEAD_BEEF;
        cpu_last = '0;
        dma_last = '0;

        step(2);
        check_all_zero("reset");
        wb_rst_i = 1'b0;
        step(1);

        $display("[TB] single CPU read");
        push_expect(1'b0, 1'b0, 32'h3800_0010, 32'd0, 4'hF, 1'b1);
        drive(1'b0, 1'b0, 32'h3800_0010, 32'd0, 4'hF);
        step(1);
        check_output("rd_mem_en", 32'(mem_en_o), 32'd1);
        check_output("rd_mem_addr", 32'(mem_addr_o), 32'd4);
        step(1);
        check_output("rd_mem_en_drop", 32'(mem_en_o), 32'd0);
        step(1);
        check_output("rd_cpu_ack", 32'(wbs_ack_o), 32'd1);
        check_output("rd_cpu_dat", wbs_dat_o, 32'hDEAD_BEEF);
        release_bus(1'b0);
        step(2);

        $display("[TB] single DMA write");
        push_expect(1'b1, 1'b1, 32'h3800_0100, 32'h1234_5678, 4'b0011, 1'b1);
        drive(1'b1, 1'b1, 32'h3800_0100, 32'h1234_5678, 4'b0011);
        step(1);
        check_output("wr_mem_we", 32'(mem_we_o), 32'h3);
        check_output("wr_mem_addr", 32'(mem_addr_o), 32'h40);
        check_output("wr_mem_wdata", mem_wdata_o, 32'h1234_5678);
        check_output("wr_grant_dma", 32'(grant_dma_o), 32'd1);
        step(2);
        check_output("wr_dma_ack", 32'(dma_ack_o), 32'd1);
        check_output("wr_dma_dat_held", dma_dat_o, dma_last);
        release_bus(1'b1);
        step(2);

        $display("[TB] CPU access outside window");
        drive(1'b0, 1'b0, 32'h3000_0000, 32'd0, 4'hF);
        en_seen = 0;
        repeat (8) begin
            step(1);
            if (mem_en_o) en_seen++;
        end
        check_output("oow_mem_en_count", 32'(en_seen), 32'd0);
        release_bus(1'b0);
        step(1);

        $display("[TB] both masters streaming after reset");
        do_reset();
        ack_who.delete();
        ack_cyc.delete();
        fork
            begin
                apply_stimulus(1'b1, 1'b0, dma_rand_adr(), 32'd0, 4'hF);
                apply_stimulus(1'b1, 1'b0, dma_rand_adr(), 32'd0, 4'hF);
            end
            begin
                apply_stimulus(1'b0, 1'b0, cpu_rand_adr(), 32'd0, 4'hF);
                apply_stimulus(1'b0, 1'b0, cpu_rand_adr(), 32'd0, 4'hF);
            end
        join
        check_output("rr_ack_count", 32'(ack_who.size()), 32'd4);
        if (ack_who.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_output($sformatf("rr_owner%0d", i), 32'(ack_who[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
                if (i > 0) check_output($sformatf("rr_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
            end
        end
        step(2);

        $display("[TB] DMA drops cyc during write");
        do_reset();
        dma_a = 32'd0;
        dma_a[11:2] = 10'd600;
        dwd = $urandom();
        cpu_a = BASE + 32'd28;
        push_expect(1'b1, 1'b1, dma_a, dwd, 4'hF, 1'b0);
        push_expect(1'b0, 1'b0, cpu_a, 32'd0, 4'hF, 1'b1);
        drive(1'b1, 1'b1, dma_a, dwd, 4'hF);
        drive(1'b0, 1'b0, cpu_a, 32'd0, 4'hF);
        step(1);
        check_output("abort_mem_we", 32'(mem_we_o), 32'hF);
        step(1);
        release_bus(1'b1);
        step(1);
        check_output("abort_no_dma_ack", 32'(dma_ack_o), 32'd0);
        check_output("abort_mem_written", mem_model[600], ref_mem[600]);
        step(3);
        check_output("abort_cpu_mem_en", 32'(mem_en_o), 32'd1);
        check_output("abort_cpu_addr", 32'(mem_addr_o), 32'd7);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            got = wbs_ack_o;
            if (!got) step(1);
        end
        check_output("abort_cpu_acked", 32'(got), 32'd1);
        release_bus(1'b0);
        step(2);

        $display("[TB] reset during access");
        do_reset();
        push_expect(1'b0, 1'b0, BASE + 32'd36, 32'd0, 4'hF, 1'b1);
        drive(1'b0, 1'b0, BASE + 32'd36, 32'd0, 4'hF);
        step(1);
        wb_rst_i = 1'b1;
        #1;
        check_all_zero("midrst");
        release_bus(1'b0);
        exp_cpu.delete();
        cpu_last = '0;
        dma_last = '0;
        step(1);
        wb_rst_i = 1'b0;
        step(1);
        push_expect(1'b0, 1'b0, BASE + 32'd36, 32'd0, 4'hF, 1'b1);
        drive(1'b0, 1'b0, BASE + 32'd36, 32'd0, 4'hF);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            step(1);
            if (wbs_ack_o) begin
                got = 1'b1;
                lat = i;
            end
        end
        check_output("post_rst_latency", 32'(lat), 32'd3);
        release_bus(1'b0);
        step(2);

        $display("[TB] random traffic");
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    step($urandom_range(0, 3));
                    apply_stimulus(1'b0, 1'($urandom_range(0, 1)), cpu_rand_adr(), $urandom(),
                                   4'($urandom_range(0, 15)));
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    step($urandom_range(0, 3));
                    apply_stimulus(1'b1, 1'($urandom_range(0, 1)), dma_rand_adr(), $urandom(),
                                   4'($urandom_range(0, 15)));
                end
            end
        join
        step(10);
        check_output("sb_cpu_drained", 32'(exp_cpu.size()), 32'd0);
        check_output("sb_dma_drained", 32'(exp_dma.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
